// File: rtl/electron_nest_top.sv
// Scaled-copy compute tile: boots five config words from the load channel, then copies
// N words from src to dst multiplied by M, repeating R passes over the dst buffer.
package electron_nest_pkg;
    localparam int unsigned WidthData  = 32;
    localparam int unsigned WidthIndex = 12;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WidthIndex-1:0] i;
        logic [WidthData-1:0]  d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module electron_nest_top
    import electron_nest_pkg::*;
#(
    parameter int unsigned WIDTH_DATA   = 32,
    parameter int unsigned WIDTH_EXADDR = 32,
    parameter int unsigned WIDTH_INDEX  = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  FTk_t                    I_Ld_FTk,
    output BTk_t                    O_Ld_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output FTk_t                    O_St_FTk,
    input  BTk_t                    I_St_BTk
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StCfg,
        StLdReq,
        StLdWait,
        StSt,
        StDone
    } state_e;

    state_e                state_q;
    logic                  hdr_cnt_q;
    logic [2:0]            cfg_cnt_q;
    logic [WIDTH_DATA-1:0] cfg_src_q;
    logic [WIDTH_DATA-1:0] cfg_dst_q;
    logic [WIDTH_DATA-1:0] cfg_n_q;
    logic [WIDTH_DATA-1:0] cfg_m_q;
    logic [WIDTH_DATA-1:0] cfg_r_q;
    logic [WIDTH_DATA-1:0] k_q;
    logic [WIDTH_DATA-1:0] p_q;

    logic [WIDTH_DATA-1:0] passes;
    logic [WIDTH_DATA-1:0] ld_base;
    logic [WIDTH_DATA-1:0] mul_lo;
    logic                  last_k;
    logic                  last_p;
    logic                  unused_inputs;

    // A pass count of zero behaves as a single pass.
    assign passes  = (cfg_r_q == '0) ? WIDTH_DATA'(1) : cfg_r_q;
    assign last_k  = (k_q == cfg_n_q - WIDTH_DATA'(1));
    assign last_p  = (p_q == passes - WIDTH_DATA'(1));
    assign ld_base = (p_q == '0) ? cfg_src_q : cfg_dst_q;
    assign mul_lo  = I_Ld_FTk.d * cfg_m_q;

    assign O_Ld_BTk      = '0;
    assign unused_inputs = ^{I_Boot, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i,
                             I_St_BTk.t, I_St_BTk.v, I_St_BTk.c};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hdr_cnt_q <= 1'b0;
            cfg_cnt_q <= '0;
            cfg_src_q <= '0;
            cfg_dst_q <= '0;
            cfg_n_q   <= '0;
            cfg_m_q   <= '0;
            cfg_r_q   <= '0;
            k_q       <= '0;
            p_q       <= '0;
            O_Ld_Req  <= 1'b0;
            O_Ld_Addr <= '0;
            O_St_Req  <= 1'b0;
            O_St_Addr <= '0;
            O_St_FTk  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (I_Ld_FTk.v && I_Ld_FTk.a) begin
                        hdr_cnt_q <= 1'b0;
                        state_q   <= StHdr;
                    end
                end
                StHdr: begin
                    if (I_Ld_FTk.v) begin
                        hdr_cnt_q <= 1'b1;
                        if (hdr_cnt_q) begin
                            cfg_cnt_q <= '0;
                            state_q   <= StCfg;
                        end
                    end
                end
                StCfg: begin
                    if (I_Ld_FTk.v) begin
                        cfg_cnt_q <= cfg_cnt_q + 3'd1;
                        case (cfg_cnt_q)
                            3'd0: cfg_src_q <= I_Ld_FTk.d;
                            3'd1: cfg_dst_q <= I_Ld_FTk.d;
                            3'd2: cfg_n_q   <= I_Ld_FTk.d;
                            3'd3: cfg_m_q   <= I_Ld_FTk.d;
                            default: begin
                                cfg_r_q <= I_Ld_FTk.d;
                                k_q     <= '0;
                                p_q     <= '0;
                                if (cfg_n_q == '0) begin
                                    state_q <= StDone;
                                end else begin
                                    O_Ld_Req  <= 1'b1;
                                    O_Ld_Addr <= WIDTH_EXADDR'(cfg_src_q);
                                    state_q   <= StLdReq;
                                end
                            end
                        endcase
                    end
                end
                StLdReq: begin
                    O_Ld_Req <= 1'b0;
                    state_q  <= StLdWait;
                end
                StLdWait: begin
                    if (I_Ld_FTk.v) begin
                        O_St_Req   <= 1'b1;
                        O_St_Addr  <= WIDTH_EXADDR'(cfg_dst_q + k_q);
                        O_St_FTk.v <= 1'b1;
                        O_St_FTk.a <= 1'b0;
                        O_St_FTk.c <= 1'b0;
                        O_St_FTk.r <= last_k && last_p;
                        O_St_FTk.i <= WIDTH_INDEX'(k_q);
                        O_St_FTk.d <= mul_lo;
                        state_q    <= StSt;
                    end
                end
                StSt: begin
                    // Store outputs stay frozen until the sink accepts (n=0).
                    if (!I_St_BTk.n) begin
                        O_St_Req <= 1'b0;
                        O_St_FTk <= '0;
                        if (!last_k) begin
                            k_q       <= k_q + WIDTH_DATA'(1);
                            O_Ld_Req  <= 1'b1;
                            O_Ld_Addr <= WIDTH_EXADDR'(ld_base + k_q + WIDTH_DATA'(1));
                            state_q   <= StLdReq;
                        end else if (!last_p) begin
                            p_q       <= p_q + WIDTH_DATA'(1);
                            k_q       <= '0;
                            O_Ld_Req  <= 1'b1;
                            O_Ld_Addr <= WIDTH_EXADDR'(cfg_dst_q);
                            state_q   <= StLdReq;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                default: begin
                    // StDone and unused encodings: park until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_electron_nest_top.sv
// Self-checking bench for electron_nest_top: random boot gaps, load latency and store
// back-pressure, checked against a pass/element loop model over a 256-word memory.
module tb_electron_nest_top;
    import electron_nest_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] d;
        logic [11:0] i;
        logic        r;
        logic        v;
        logic        a;
        logic        c;
    } st_rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        boot_ind = 1'b0;
    logic        ld_req;
    logic [31:0] ld_addr;
    FTk_t        ld_ftk = '0;
    BTk_t        ld_btk;
    logic        st_req;
    logic [31:0] st_addr;
    FTk_t        st_ftk;
    BTk_t        st_btk = '0;

    logic [31:0] mem [256];
    logic [31:0] ld_log [$];
    st_rec_t     st_log [$];
    int          hold_bad;
    int          stall_seen;
    bit          timed_out;
    int          total = 0;
    int          bad = 0;

    electron_nest_top dut (
        .clock     (clock),
        .reset     (reset),
        .I_Boot    (boot_ind),
        .O_Ld_Req  (ld_req),
        .O_Ld_Addr (ld_addr),
        .I_Ld_FTk  (ld_ftk),
        .O_Ld_BTk  (ld_btk),
        .O_St_Req  (st_req),
        .O_St_Addr (st_addr),
        .O_St_FTk  (st_ftk),
        .I_St_BTk  (st_btk)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        reset  = 1'b1;
        ld_ftk = '0;
        st_btk = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
    endtask

    task automatic boot(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] n,
                        input logic [31:0] m, input logic [31:0] r);
        logic [31:0] words [8];
        words = '{$urandom, $urandom, $urandom, c0, c1, n, m, r};
        boot_ind = 1'b1;
        for (int w = 0; w < 8; w++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                @(negedge clock);
                ld_ftk   = '0;
                ld_ftk.a = 1'($urandom_range(0, 1));
                ld_ftk.d = $urandom;
            end
            if (w == 0) begin
                // Valid but non-acquire token must be ignored while idle.
                @(negedge clock);
                ld_ftk   = '0;
                ld_ftk.v = 1'b1;
                ld_ftk.d = $urandom;
            end
            @(negedge clock);
            ld_ftk   = '0;
            ld_ftk.v = 1'b1;
            ld_ftk.a = (w == 0) ? 1'b1 : (w < 3 ? 1'($urandom_range(0, 1)) : 1'b0);
            ld_ftk.d = words[w];
        end
        boot_ind = 1'b0;
    endtask

    // Serves loads from mem, sinks stores into mem, injects junk tokens where they must be
    // discarded, and logs every request it sees.
    task automatic run_job(input int exp_stores, input int idle_cycles, input int bp_first,
                           input bit rand_bp);
        int          pend;
        int          idle;
        int          bp_left;
        bit          stalled;
        logic [31:0] paddr;
        logic [31:0] snap_addr;
        FTk_t        snap_ftk;
        st_rec_t     rec;
        pend      = 0;
        idle      = 0;
        bp_left   = bp_first;
        stalled   = 1'b0;
        paddr     = '0;
        snap_addr = '0;
        snap_ftk  = '0;
        ld_log.delete();
        st_log.delete();
        hold_bad   = 0;
        stall_seen = 0;
        timed_out  = 1'b0;
        for (int cyc = 0; idle < idle_cycles; cyc++) begin
            if (cyc >= 4000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clock);
            ld_ftk = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ld_ftk.v = 1'b1;
                    ld_ftk.d = mem[paddr[7:0]];
                end
            end else if ((ld_req || st_req || st_log.size() >= exp_stores) &&
                         $urandom_range(0, 1) == 1) begin
                ld_ftk.v = 1'b1;
                ld_ftk.a = 1'($urandom_range(0, 1));
                ld_ftk.d = $urandom;
            end
            if (ld_req) begin
                ld_log.push_back(ld_addr);
                paddr = ld_addr;
                pend  = $urandom_range(1, 3);
            end
            st_btk.t = 1'($urandom_range(0, 1));
            st_btk.v = 1'($urandom_range(0, 1));
            st_btk.c = 1'($urandom_range(0, 1));
            if (st_req) begin
                if (stalled && (st_addr !== snap_addr || st_ftk !== snap_ftk)) hold_bad++;
                if (bp_left > 0) begin
                    st_btk.n = 1'b1;
                    bp_left--;
                end else begin
                    st_btk.n = rand_bp && ($urandom_range(0, 3) == 0);
                end
                if (st_btk.n) begin
                    stall_seen++;
                end else begin
                    rec = '{addr: st_addr, d: st_ftk.d, i: st_ftk.i, r: st_ftk.r,
                            v: st_ftk.v, a: st_ftk.a, c: st_ftk.c};
                    st_log.push_back(rec);
                    mem[st_addr[7:0]] = st_ftk.d;
                end
                stalled   = st_btk.n;
                snap_addr = st_addr;
                snap_ftk  = st_ftk;
            end else begin
                if (stalled) hold_bad++;
                st_btk.n = 1'($urandom_range(0, 1));
                stalled  = 1'b0;
            end
            if (st_log.size() >= exp_stores && pend == 0 && !ld_req) idle++;
        end
        ld_ftk = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({ld_req, st_req} !== 2'b00) begin
            bad++;
            $display("FAIL reset_req: got ld=%b st=%b, want 0 0", ld_req, st_req);
        end
        total++;
        if ({ld_addr, st_addr} !== 64'd0) begin
            bad++;
            $display("FAIL reset_addr: got %h %h, want 0 0", ld_addr, st_addr);
        end
        total++;
        if (st_ftk !== '0 || ld_btk !== '0) begin
            bad++;
            $display("FAIL reset_tok: got st_ftk=%h ld_btk=%h, want 0 0", st_ftk, ld_btk);
        end
        reset = 1'b0;
    endtask

    task automatic test_scaled_copy(input string name, input logic [31:0] c0,
                                    input logic [31:0] c1, input int n, input logic [31:0] m,
                                    input int r, input bit do_rst, input bit rand_bp);
        logic [31:0] model [256];
        logic [31:0] exp_ld [$];
        st_rec_t     exp_st [$];
        logic [31:0] src;
        logic [31:0] la;
        logic [31:0] sa;
        logic [31:0] kk;
        logic [31:0] val;
        st_rec_t     e;
        int          passes;
        int          mem_bad;
        if (do_rst) apply_reset();
        model  = mem;
        passes = (r == 0) ? 1 : r;
        for (int p = 0; p < passes; p++) begin
            src = (p == 0) ? c0 : c1;
            for (int k = 0; k < n; k++) begin
                kk  = k;
                la  = src + kk;
                sa  = c1 + kk;
                val = model[la[7:0]] * m;
                model[sa[7:0]] = val;
                exp_ld.push_back(la);
                e = '{addr: sa, d: val, i: kk[11:0], r: (p == passes - 1 && k == n - 1),
                      v: 1'b1, a: 1'b0, c: 1'b0};
                exp_st.push_back(e);
            end
        end
        boot(c0, c1, n, m, r);
        run_job(exp_st.size(), 20, 0, rand_bp);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s timeout: got %0d stores, want %0d", name, st_log.size(),
                     exp_st.size());
        end
        total++;
        if (ld_log.size() != exp_ld.size()) begin
            bad++;
            $display("FAIL %s load_count: got %0d, want %0d", name, ld_log.size(), exp_ld.size());
        end
        for (int i = 0; i < exp_ld.size() && i < ld_log.size(); i++) begin
            total++;
            if (ld_log[i] !== exp_ld[i]) begin
                bad++;
                $display("FAIL %s load_addr[%0d]: got %h, want %h", name, i, ld_log[i], exp_ld[i]);
            end
        end
        total++;
        if (st_log.size() != exp_st.size()) begin
            bad++;
            $display("FAIL %s store_count: got %0d, want %0d", name, st_log.size(), exp_st.size());
        end
        for (int i = 0; i < exp_st.size() && i < st_log.size(); i++) begin
            total++;
            if (st_log[i] !== exp_st[i]) begin
                bad++;
                $display("FAIL %s store[%0d]: got addr=%h d=%h i=%h r=%b v=%b a=%b c=%b, want addr=%h d=%h i=%h r=%b v=1 a=0 c=0",
                         name, i, st_log[i].addr, st_log[i].d, st_log[i].i, st_log[i].r,
                         st_log[i].v, st_log[i].a, st_log[i].c, exp_st[i].addr, exp_st[i].d,
                         exp_st[i].i, exp_st[i].r);
            end
        end
        mem_bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== model[a]) mem_bad++;
        total++;
        if (mem_bad != 0) begin
            bad++;
            $display("FAIL %s memory: got %0d differing words, want 0", name, mem_bad);
        end
    endtask

    task automatic test_basic();
        fill_mem();
        for (int i = 0; i < 4; i++) mem[16 + i] = i + 1;
        test_scaled_copy("basic", 32'd16, 32'd32, 4, 32'd2, 1, 1'b1, 1'b1);
        total++;
        if ({mem[32], mem[33], mem[34], mem[35]} !== {32'd2, 32'd4, 32'd6, 32'd8}) begin
            bad++;
            $display("FAIL basic_result: got %0d %0d %0d %0d, want 2 4 6 8",
                     mem[32], mem[33], mem[34], mem[35]);
        end
    endtask

    task automatic test_repeat();
        fill_mem();
        for (int i = 0; i < 4; i++) mem[16 + i] = i + 1;
        test_scaled_copy("repeat", 32'd16, 32'd32, 4, 32'd2, 2, 1'b1, 1'b1);
        total++;
        if ({mem[32], mem[33], mem[34], mem[35]} !== {32'd4, 32'd8, 32'd12, 32'd16}) begin
            bad++;
            $display("FAIL repeat_result: got %0d %0d %0d %0d, want 4 8 12 16",
                     mem[32], mem[33], mem[34], mem[35]);
        end
    endtask

    task automatic test_zero_n();
        apply_reset();
        fill_mem();
        boot(32'd16, 32'd32, 32'd0, 32'd2, 32'd1);
        run_job(0, 40, 0, 1'b1);
        total++;
        if (ld_log.size() != 0 || st_log.size() != 0 || timed_out) begin
            bad++;
            $display("FAIL zero_n: got %0d loads %0d stores, want 0 0", ld_log.size(),
                     st_log.size());
        end
    endtask

    task automatic test_trunc();
        fill_mem();
        mem[16] = 32'h8000_0001;
        test_scaled_copy("trunc", 32'd16, 32'd32, 1, 32'd2, 1, 1'b1, 1'b0);
        total++;
        if (mem[32] !== 32'h0000_0002) begin
            bad++;
            $display("FAIL trunc_result: got %h, want 00000002", mem[32]);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        fill_mem();
        for (int i = 0; i < 4; i++) mem[16 + i] = i + 1;
        boot(32'd16, 32'd32, 32'd4, 32'd2, 32'd1);
        run_job(4, 20, 3, 1'b0);
        total++;
        if (stall_seen != 3 || timed_out) begin
            bad++;
            $display("FAIL bp_stalls: got %0d stalled cycles, want 3", stall_seen);
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d changed cycles while stalled, want 0", hold_bad);
        end
        total++;
        if (st_log.size() != 4) begin
            bad++;
            $display("FAIL bp_store_count: got %0d, want 4", st_log.size());
        end else begin
            total++;
            if (st_log[0].addr !== 32'd32 || st_log[0].d !== 32'd2) begin
                bad++;
                $display("FAIL bp_first_store: got addr=%0d d=%0d, want addr=32 d=2",
                         st_log[0].addr, st_log[0].d);
            end
        end
        total++;
        if ({mem[32], mem[33], mem[34], mem[35]} !== {32'd2, 32'd4, 32'd6, 32'd8}) begin
            bad++;
            $display("FAIL bp_result: got %0d %0d %0d %0d, want 2 4 6 8",
                     mem[32], mem[33], mem[34], mem[35]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        fill_mem();
        for (int i = 0; i < 4; i++) mem[16 + i] = i + 1;
        boot(32'd16, 32'd32, 32'd4, 32'd2, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            ld_ftk = '0;
            seen   = ld_req;
        end
        @(negedge clock);
        total++;
        if (!seen || ld_req !== 1'b0 || ld_addr !== 32'd16) begin
            bad++;
            $display("FAIL abort_wait: got seen=%b req=%b addr=%0d, want 1 0 16", seen, ld_req,
                     ld_addr);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({ld_req, st_req, ld_addr, st_addr, st_ftk, ld_btk} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got req=%b/%b addr=%h/%h, want all 0", ld_req, st_req,
                     ld_addr, st_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mem[16 + i] = i + 1;
        test_scaled_copy("after_abort", 32'd16, 32'd32, 4, 32'd2, 1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] c0;
        logic [31:0] c1;
        for (int t = 0; t < 5; t++) begin
            fill_mem();
            c0 = (t == 0) ? 32'hFFFF_FFFE : $urandom;
            c1 = $urandom;
            test_scaled_copy("random", c0, c1, $urandom_range(1, 6), $urandom,
                             $urandom_range(0, 3), 1'b1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_zero_n();
        test_trunc();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
